demux_stage: RTL and testbench
==============================

Name: demux_stage

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the inverse of the datapath mux.
- Takes one input stream and steers each word to output port 1 or port 2, according to a per-word select.
- Used where a single producer (e.g. memory read-data) must feed one of two consumers (e.g. operand A path vs. operand B path).
- Each output has its own one-entry holding slot, so a stalled consumer never blocks the other port. Per-port transfer counters and a sticky protocol-error flag support debug.

Parameters:
- WIDTH, 8, data width of input and both outputs
- CNT_WIDTH, 16, width of per-port transfer counters

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 = port 1, 1 = port 2
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the word this cycle
- out1_data  output  WIDTH  port 1 word
- out1_valid  output  1  port 1 word present
- out1_ready  input  1  port 1 consumer accepts
- out2_data  output  WIDTH  port 2 word
- out2_valid  output  1  port 2 word present
- out2_ready  input  1  port 2 consumer accepts
- cnt1  output  CNT_WIDTH  completed port 1 transfers
- cnt2  output  CNT_WIDTH  completed port 2 transfers
- proto_err  output  1  sticky: input changed while stalled

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state: both slots EMPTY; outk_valid=0, outk_data=0, cnt1=cnt2=0, proto_err=0.
  - Reset mid-transfer discards held words with no handshake.
  - in_ready is 0 during any cycle where reset=1.
- Per-slot state machine (k = 1, 2), with fire_out_k = outk_valid && outk_ready and fire_in_k = in_valid && in_ready && (in_sel == k-1):
  - EMPTY -> FULL on fire_in_k.
  - FULL -> EMPTY on fire_out_k && !fire_in_k.
  - FULL stays FULL on fire_in_k && fire_out_k. The slot is reloaded with the new word; this gives pass-through at 1 word/cycle.
  - FULL with neither event: hold the data unchanged.
- in_ready = !reset && (slot[in_sel] EMPTY || outk_ready for k = in_sel).
  - in_ready is combinational from in_sel and outk_ready.
  - It never depends on in_valid.
- Latency: an accepted word appears on outk_data/outk_valid the cycle after acceptance.
- Ordering:
  - Per port, order is preserved.
  - Across ports, there is no ordering relation.
- outk_data is stable while outk_valid && !outk_ready. An asserted outk_valid only deasserts after fire_out_k.
- Counters:
  - cntk increments by 1 on fire_out_k.
  - Modulo 2^CNT_WIDTH: all-ones wraps to 0 with no flag.
- proto_err:
  - Record the input as stalled on a cycle with in_valid && !in_ready.
  - On the next cycle, if in_valid dropped, or in_sel changed, or in_data changed, set proto_err=1.
  - proto_err clears only on reset.
  - The data path still follows the current inputs.
- Simultaneous events:
  - An input to port 1 and a drain of port 2 in the same cycle are independent.
  - At most one slot loads per cycle.

Decomposition:
- Package demux_pkg:
  - typedef enum logic {DEST_1=1'b0, DEST_2=1'b1} dest_e
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e
- Sub-module demux_slot (parameter WIDTH):
  - One-entry register slice with load/valid/ready, reset to EMPTY with data 0.
  - Instantiated twice.
  - Counters, ready steering and proto_err stay in the top level.

Test Plan:
- Reset check: assert reset 2 cycles with in_valid=1 -> in_ready=0, out1_valid=out2_valid=0, cnt1=cnt2=0, proto_err=0.
- Steering: both readys=1; send 0xA5 sel=0 then 0x3C sel=1 on consecutive cycles.
  - out1 shows 0xA5 one cycle after acceptance.
  - out2 shows 0x3C one cycle later.
  - cnt1=1, cnt2=1.
- Independent stall: out1_ready=0; send 0x11 sel=0, then 0x22 sel=0, then 0x33 sel=1.
  - out1_data holds 0x11; in_ready=0 on the 0x22 cycle.
  - Then hold 0x22 with sel=0 and in_valid=1, and raise out1_ready.
  - 0x22 is accepted; proto_err stays 0.
  - Afterwards 0x33 is accepted and appears on out2 while out1 was stalled.
- Full throughput: both readys=1; send 10 words alternating sel, one per cycle.
  - in_ready is constant 1.
  - Outputs match inputs in order per port.
  - cnt1=5, cnt2=5.
- Counter wrap: CNT_WIDTH=4, 17 transfers to port 2 -> cnt2=1, cnt1=0.
- Protocol error and mid-operation reset:
  - Stall port 1 with 0x11 held; present 0x44 sel=0 with in_ready=0.
  - Change it to 0x55 next cycle -> proto_err=1 and remains 1.
  - Then pulse reset -> proto_err=0, out1_valid=0, and 0x11 is never delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the registered 1-to-2 demultiplexer.
package demux_pkg;

  // Destination encoding carried on in_sel.
  typedef enum logic {
    DEST_1 = 1'b0,
    DEST_2 = 1'b1
  } dest_e;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: loads a word, presents it with valid, and
// releases it when the downstream consumer accepts it.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  slot_state_e             state;
  logic        [WIDTH-1:0] data_q;

  // Slot occupancy and stored word; a load always wins, so a slot that
  // drains and reloads in the same cycle stays FULL with the new word.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= SLOT_EMPTY;
      data_q <= '0;
    end else if (load) begin
      state  <= SLOT_FULL;
      data_q <= load_data;
    end else if (state == SLOT_FULL && ready) begin
      state  <= SLOT_EMPTY;
    end
  end

  assign data  = data_q;
  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_stage.sv
// Registered 1-to-2 demultiplexer with valid/ready on every port, one
// holding slot per output, per-port transfer counters and a sticky flag
// for inputs that change while stalled.
module demux_stage
  import demux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out2_data,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic                 proto_err
);

  dest_e            dest;
  logic             fire_in;
  logic             load1;
  logic             load2;
  logic             fire_out1;
  logic             fire_out2;
  logic             stalled_q;
  dest_e            sel_q;
  logic [WIDTH-1:0] data_q;

  assign dest = dest_e'(in_sel);

  // The addressed slot can take a word if it is empty or draining this
  // cycle; in_valid is deliberately not part of this term.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (dest == DEST_1) in_ready = !out1_valid || out1_ready;
      else                in_ready = !out2_valid || out2_ready;
    end
  end

  assign fire_in   = in_valid && in_ready;
  assign load1     = fire_in && (dest == DEST_1);
  assign load2     = fire_in && (dest == DEST_2);
  assign fire_out1 = out1_valid && out1_ready;
  assign fire_out2 = out2_valid && out2_ready;

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .load      (load1),
    .load_data (in_data),
    .ready     (out1_ready),
    .data      (out1_data),
    .valid     (out1_valid)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clock     (clock),
    .reset     (reset),
    .load      (load2),
    .load_data (in_data),
    .ready     (out2_ready),
    .data      (out2_data),
    .valid     (out2_valid)
  );

  // Completed-transfer counters; they wrap silently at full scale.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (fire_out1) cnt1 <= cnt1 + 1'b1;
      if (fire_out2) cnt2 <= cnt2 + 1'b1;
    end
  end

  // Remember a stalled input and flag it if it is withdrawn or altered on
  // the following cycle; the flag holds until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stalled_q <= 1'b0;
      sel_q     <= DEST_1;
      data_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      stalled_q <= in_valid && !in_ready;
      sel_q     <= dest;
      data_q    <= in_data;
      if (stalled_q && (!in_valid || dest != sel_q || in_data != data_q))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stage.sv
// Directed self-checking bench for demux_stage. A second instance with a
// 4-bit counter shares the stimulus so counter wrap can be observed.
module tb_demux_stage;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             out1_ready;
  logic             out2_ready;

  logic             in_ready,   in_ready_w;
  logic [WIDTH-1:0] out1_data,  out1_data_w;
  logic             out1_valid, out1_valid_w;
  logic [WIDTH-1:0] out2_data,  out2_data_w;
  logic             out2_valid, out2_valid_w;
  logic [15:0]      cnt1, cnt2;
  logic [3:0]       cnt1_w, cnt2_w;
  logic             proto_err,  proto_err_w;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  demux_stage #(.WIDTH(WIDTH), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2), .proto_err(proto_err)
  );

  demux_stage #(.WIDTH(WIDTH), .CNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready_w),
    .out1_data(out1_data_w), .out1_valid(out1_valid_w), .out1_ready(out1_ready),
    .out2_data(out2_data_w), .out2_valid(out2_valid_w), .out2_ready(out2_ready),
    .cnt1(cnt1_w), .cnt2(cnt2_w), .proto_err(proto_err_w)
  );

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h77);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_late got %b exp 0", in_ready);
    end
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b%b exp 00", out1_valid, out2_valid);
    end
    checks++;
    if (out1_data !== 8'h00 || out2_data !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h %h exp 00 00", out1_data, out2_data);
    end
    checks++;
    if (cnt1 !== 16'd0 || cnt2 !== 16'd0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err got %0d %0d %b exp 0 0 0", cnt1, cnt2, proto_err);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_steering();
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'hA5);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL steer_in_ready got %b exp 1", in_ready);
    end
    tick();
    drive(1'b1, 1'b1, 8'h3C);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'hA5 || out2_valid !== 1'b0) begin
      errors++; $display("FAIL steer_out1 got v%b %h v2=%b exp v1 a5 v2=0", out1_valid, out1_data, out2_valid);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 8'h3C || out1_valid !== 1'b0) begin
      errors++; $display("FAIL steer_out2 got v%b %h v1=%b exp v1 3c v1=0", out2_valid, out2_data, out1_valid);
    end
    tick();
    checks++;
    if (cnt1 !== 16'd1 || cnt2 !== 16'd1) begin
      errors++; $display("FAIL steer_cnt got %0d %0d exp 1 1", cnt1, cnt2);
    end
  endtask

  task automatic test_independent_stall();
    do_reset();
    out1_ready = 1'b0;
    out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b0, 8'h22);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready);
    end
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h11) begin
      errors++; $display("FAIL stall_out1_hold got v%b %h exp v1 11", out1_valid, out1_data);
    end
    tick();
    checks++;
    if (out1_data !== 8'h11) begin
      errors++; $display("FAIL stall_out1_stable got %h exp 11", out1_data);
    end
    out1_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready);
    end
    tick();
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h33);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h22 || cnt1 !== 16'd1) begin
      errors++; $display("FAIL stall_out1_next got v%b %h cnt %0d exp v1 22 cnt 1", out1_valid, out1_data, cnt1);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_port2_ready got %b exp 1", in_ready);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 8'h33 || out1_data !== 8'h22 || out1_valid !== 1'b1) begin
      errors++; $display("FAIL stall_out2 got v%b %h out1 %h exp v1 33 out1 22", out2_valid, out2_data, out1_data);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL stall_proto_err got %b exp 0", proto_err);
    end
    out1_ready = 1'b1;
    tick();
  endtask

  task automatic test_full_throughput();
    logic [7:0] exp_d;
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d = 8'h40 + 8'(i);
      drive(1'b1, i[0], exp_d);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL thru_in_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (i[0] == 1'b0 && (out1_valid !== 1'b1 || out1_data !== exp_d)) begin
        errors++; $display("FAIL thru_out1[%0d] got v%b %h exp v1 %h", i, out1_valid, out1_data, exp_d);
      end else if (i[0] == 1'b1 && (out2_valid !== 1'b1 || out2_data !== exp_d)) begin
        errors++; $display("FAIL thru_out2[%0d] got v%b %h exp v1 %h", i, out2_valid, out2_data, exp_d);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (cnt1 !== 16'd5 || cnt2 !== 16'd5) begin
      errors++; $display("FAIL thru_cnt got %0d %0d exp 5 5", cnt1, cnt2);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (cnt2_w !== 4'd1 || cnt1_w !== 4'd0) begin
      errors++; $display("FAIL wrap_cnt4 got %0d %0d exp cnt2 1 cnt1 0", cnt2_w, cnt1_w);
    end
    checks++;
    if (cnt2 !== 16'd17) begin
      errors++; $display("FAIL wrap_cnt16 got %0d exp 17", cnt2);
    end
  endtask

  task automatic test_proto_err_reset();
    do_reset();
    out1_ready = 1'b0;
    out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b0, 8'h44);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL perr_in_ready got %b exp 0", in_ready);
    end
    tick();
    drive(1'b1, 1'b0, 8'h55);
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL perr_set got %b exp 1", proto_err);
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checks++;
    if (proto_err !== 1'b1 || out1_data !== 8'h11) begin
      errors++; $display("FAIL perr_sticky got %b data %h exp 1 data 11", proto_err, out1_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL perr_reset got err %b v1 %b exp 0 0", proto_err, out1_valid);
    end
    out1_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out1_valid !== 1'b0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL perr_discard got v1 %b cnt1 %0d exp 0 0", out1_valid, cnt1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    test_reset();
    test_steering();
    test_independent_stall();
    test_full_throughput();
    test_counter_wrap();
    test_proto_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
